// File: rtl/systolic_pq_sched.sv
// systolic_pq_sched
//   Front-end scheduler for the systolic priority queue. Round-robin arbitration
//   of NREQ insert requesters onto the queue's single insert port, min-extract
//   requests from one consumer, and a flush sequence that drains the queue
//   through repeated extracts. Operations are issued only while `even`=1.
//   An occupancy count guards against overfilling and over-draining.
//
// Ports
//   clk, rst       clock / asynchronous active-low reset
//   even           queue phase; issue slots exist only while high
//   req_valid/data per-requester insert request and entry
//   req_rdy        one-hot grant (combinational)
//   deq_req/ack    consumer extract request / extract issued this cycle
//   flush          start a drain to empty (sampled in RUN)
//   flush_done     one-cycle pulse when the drain completes
//   pq_ivalid/idata insert strobe and entry to the queue (+inf when idle)
//   pq_ovalid      extract strobe to the queue
//   pq_irdy        queue can accept an insert
//   count/full/empty occupancy and flags
//
// State table
//   state   | meaning
//   S_RUN   | normal operation: extracts first, then round-robin inserts
//   S_DRAIN | one extract per slot until empty, then flush_done and back to RUN

module systolic_pq_sched #(
    parameter int KW       = 8,
    parameter int VW       = 4,
    parameter int NREQ     = 4,
    parameter int CAPACITY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     even,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*(KW+VW)-1:0]  req_data,
    output logic [NREQ-1:0]          req_rdy,
    input  logic                     deq_req,
    output logic                     deq_ack,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     pq_ivalid,
    output logic [KW+VW-1:0]         pq_idata,
    output logic                     pq_ovalid,
    input  logic                     pq_irdy,
    output logic [3:0]               count,
    output logic                     full,
    output logic                     empty
);

    localparam int EW = KW + VW;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {S_RUN, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [3:0]      count_q, count_d;
    logic            slot;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_found;

    // rst is folded into the slot so every strobe is forced low during reset
    assign slot  = even & rst;
    assign count = count_q;
    assign full  = (count_q == 4'(CAPACITY));
    assign empty = (count_q == 4'd0);

    // First valid requester at or after ptr, wrapping modulo NREQ
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        req_rdy    = '0;
        deq_ack    = 1'b0;
        pq_ivalid  = 1'b0;
        pq_ovalid  = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            S_RUN: begin
                if (slot && deq_req && !empty) begin
                    pq_ovalid = 1'b1;
                    deq_ack   = 1'b1;
                    count_d   = count_q - 4'd1;
                end else if (slot && !full && pq_irdy && gnt_found) begin
                    req_rdy[gnt_idx] = 1'b1;
                    pq_ivalid        = 1'b1;
                    count_d          = count_q + 4'd1;
                    ptr_d            = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
                end
                // an operation issued alongside the flush request still completes
                if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // completion does not wait for a slot
                if (empty) begin
                    flush_done = 1'b1;
                    state_d    = S_RUN;
                end else if (slot) begin
                    pq_ovalid = 1'b1;
                    count_d   = count_q - 4'd1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // idle insert data is +infinity so the queue never sees a stale key
    always_comb begin
        pq_idata = '1;
        if (pq_ivalid) begin
            pq_idata = req_data[gnt_idx*EW +: EW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            ptr_q   <= '0;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_systolic_pq_sched.sv
module tb_systolic_pq_sched;

    localparam int KW   = 8;
    localparam int VW   = 4;
    localparam int NREQ = 4;
    localparam int EW   = KW + VW;

    logic                 clk;
    logic                 rst;
    logic                 even;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*EW-1:0]   req_data;
    logic [NREQ-1:0]      req_rdy;
    logic                 deq_req;
    logic                 deq_ack;
    logic                 flush;
    logic                 flush_done;
    logic                 pq_ivalid;
    logic [EW-1:0]        pq_idata;
    logic                 pq_ovalid;
    logic                 pq_irdy;
    logic [3:0]           count;
    logic                 full;
    logic                 empty;

    int total = 0;
    int bad   = 0;

    systolic_pq_sched #(.KW(KW), .VW(VW), .NREQ(NREQ), .CAPACITY(4)) dut (
        .clk(clk), .rst(rst), .even(even),
        .req_valid(req_valid), .req_data(req_data), .req_rdy(req_rdy),
        .deq_req(deq_req), .deq_ack(deq_ack),
        .flush(flush), .flush_done(flush_done),
        .pq_ivalid(pq_ivalid), .pq_idata(pq_idata), .pq_ovalid(pq_ovalid),
        .pq_irdy(pq_irdy),
        .count(count), .full(full), .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ev;
        logic [3:0]  vld;
        logic        deq;
        logic        irdy;
        logic [3:0]  e_rdy;
        logic        e_ack;
        logic [11:0] e_idata;
        logic        e_oval;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic ev, logic [3:0] vld, logic deq, logic irdy,
                                logic [3:0] rdy, logic ack, logic [11:0] idata,
                                logic oval, logic [3:0] cnt);
        vec_t v;
        v.ev = ev; v.vld = vld; v.deq = deq; v.irdy = irdy;
        v.e_rdy = rdy; v.e_ack = ack; v.e_idata = idata; v.e_oval = oval; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"},   32'(req_rdy), 0);
        chk({tag, "_ack"},   32'(deq_ack), 0);
        chk({tag, "_ival"},  32'(pq_ivalid), 0);
        chk({tag, "_oval"},  32'(pq_ovalid), 0);
        chk({tag, "_done"},  32'(flush_done), 0);
        chk({tag, "_idata"}, 32'(pq_idata), 32'hFFF);
        chk({tag, "_cnt"},   32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"},  32'(full), 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ov_n;
        int done_n;
        int bad_grant;
        bit done_seen;

        rst       = 1'b0;
        even      = 1'b0;
        req_valid = '0;
        req_data  = {12'h040, 12'h030, 12'h020, 12'h010};
        deq_req   = 1'b0;
        flush     = 1'b0;
        pq_irdy   = 1'b1;

        // ev, vld, deq, irdy | rdy, ack, idata, oval, count-before-edge
        vq.push_back(mk(0, 4'hF, 0, 1, 4'h0, 0, 12'hFFF, 0, 0));
        vq.push_back(mk(1, 4'hF, 0, 1, 4'h1, 0, 12'h010, 0, 0));
        vq.push_back(mk(0, 4'hF, 0, 1, 4'h0, 0, 12'hFFF, 0, 1));
        vq.push_back(mk(1, 4'hF, 0, 1, 4'h2, 0, 12'h020, 0, 1));
        vq.push_back(mk(0, 4'hF, 0, 1, 4'h0, 0, 12'hFFF, 0, 2));
        vq.push_back(mk(1, 4'hF, 0, 1, 4'h4, 0, 12'h030, 0, 2));
        vq.push_back(mk(0, 4'hF, 0, 1, 4'h0, 0, 12'hFFF, 0, 3));
        vq.push_back(mk(1, 4'hF, 0, 1, 4'h8, 0, 12'h040, 0, 3));
        vq.push_back(mk(0, 4'hF, 0, 1, 4'h0, 0, 12'hFFF, 0, 4));
        vq.push_back(mk(1, 4'hF, 0, 1, 4'h0, 0, 12'hFFF, 0, 4));
        vq.push_back(mk(0, 4'h0, 1, 1, 4'h0, 0, 12'hFFF, 0, 4));
        vq.push_back(mk(1, 4'h2, 1, 1, 4'h0, 1, 12'hFFF, 1, 4));
        vq.push_back(mk(0, 4'h2, 0, 1, 4'h0, 0, 12'hFFF, 0, 3));
        vq.push_back(mk(1, 4'h2, 0, 1, 4'h2, 0, 12'h020, 0, 3));
        vq.push_back(mk(0, 4'h0, 0, 1, 4'h0, 0, 12'hFFF, 0, 4));
        vq.push_back(mk(1, 4'h0, 1, 1, 4'h0, 1, 12'hFFF, 1, 4));
        vq.push_back(mk(0, 4'h0, 0, 1, 4'h0, 0, 12'hFFF, 0, 3));
        vq.push_back(mk(1, 4'h0, 1, 1, 4'h0, 1, 12'hFFF, 1, 3));
        vq.push_back(mk(0, 4'h0, 0, 1, 4'h0, 0, 12'hFFF, 0, 2));
        vq.push_back(mk(1, 4'h2, 1, 1, 4'h0, 1, 12'hFFF, 1, 2));
        vq.push_back(mk(0, 4'h2, 0, 1, 4'h0, 0, 12'hFFF, 0, 1));
        vq.push_back(mk(1, 4'h2, 0, 1, 4'h2, 0, 12'h020, 0, 1));
        vq.push_back(mk(0, 4'h0, 0, 1, 4'h0, 0, 12'hFFF, 0, 2));
        vq.push_back(mk(1, 4'h1, 0, 0, 4'h0, 0, 12'hFFF, 0, 2));
        vq.push_back(mk(0, 4'h1, 0, 0, 4'h0, 0, 12'hFFF, 0, 2));
        vq.push_back(mk(1, 4'h1, 1, 0, 4'h0, 1, 12'hFFF, 1, 2));
        vq.push_back(mk(0, 4'h0, 0, 1, 4'h0, 0, 12'hFFF, 0, 1));
        vq.push_back(mk(1, 4'h0, 1, 1, 4'h0, 1, 12'hFFF, 1, 1));
        vq.push_back(mk(0, 4'h0, 0, 1, 4'h0, 0, 12'hFFF, 0, 0));
        vq.push_back(mk(1, 4'h4, 1, 1, 4'h4, 0, 12'h030, 0, 0));
        vq.push_back(mk(0, 4'h0, 0, 1, 4'h0, 0, 12'hFFF, 0, 1));
        vq.push_back(mk(1, 4'h9, 0, 1, 4'h8, 0, 12'h040, 0, 1));
        vq.push_back(mk(0, 4'h9, 0, 1, 4'h0, 0, 12'hFFF, 0, 2));
        vq.push_back(mk(1, 4'h9, 0, 1, 4'h1, 0, 12'h010, 0, 2));
        vq.push_back(mk(0, 4'h0, 0, 1, 4'h0, 0, 12'hFFF, 0, 3));

        // reset state, with even and requests high to show strobes are forced off
        #2;
        even = 1'b1; req_valid = 4'hF; deq_req = 1'b1;
        @(negedge clk);
        chk_reset_outs("rst0");
        even = 1'b0; req_valid = '0; deq_req = 1'b0;
        next_cycle();
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            even      = vq[i].ev;
            req_valid = vq[i].vld;
            deq_req   = vq[i].deq;
            pq_irdy   = vq[i].irdy;
            flush     = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i),   32'(req_rdy),   32'(vq[i].e_rdy));
            chk($sformatf("v%0d_ack", i),   32'(deq_ack),   32'(vq[i].e_ack));
            chk($sformatf("v%0d_ival", i),  32'(pq_ivalid), 32'(|vq[i].e_rdy));
            chk($sformatf("v%0d_idata", i), 32'(pq_idata),  32'(vq[i].e_idata));
            chk($sformatf("v%0d_oval", i),  32'(pq_ovalid), 32'(vq[i].e_oval));
            chk($sformatf("v%0d_cnt", i),   32'(count),     32'(vq[i].e_cnt));
            chk($sformatf("v%0d_full", i),  32'(full),      32'(vq[i].e_cnt == 4'd4));
            chk($sformatf("v%0d_empty", i), 32'(empty),     32'(vq[i].e_cnt == 4'd0));
            next_cycle();
        end

        // flush from occupancy 3 (ptr = 1 at this point)
        pq_irdy = 1'b1;
        even = 1'b0; req_valid = 4'hF; deq_req = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("fl_req_rdy", 32'(req_rdy), 0);
        chk("fl_req_cnt", 32'(count), 3);
        next_cycle();
        flush = 1'b0;
        ov_n = 0; done_n = 0; bad_grant = 0; done_seen = 1'b0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            even = (c % 2 == 0);
            @(negedge clk);
            if (pq_ovalid) ov_n++;
            if (req_rdy != 0 || deq_ack || pq_ivalid) bad_grant++;
            if (flush_done) begin
                done_n++;
                done_seen = 1'b1;
                chk("fl_done_cnt", 32'(count), 0);
            end
            next_cycle();
        end
        chk("fl_ov_pulses", 32'(ov_n), 3);
        chk("fl_done_pulses", 32'(done_n), 1);
        chk("fl_no_grants", 32'(bad_grant), 0);
        // back in RUN: grant resumes from ptr = 1
        even = 1'b1; req_valid = 4'hF; deq_req = 1'b0;
        @(negedge clk);
        chk("fl_after_done", 32'(flush_done), 0);
        chk("fl_after_rdy", 32'(req_rdy), 32'h2);
        chk("fl_after_idata", 32'(pq_idata), 32'h020);
        next_cycle();

        // flush with an already-empty queue: done one cycle after entry
        even = 1'b0; req_valid = '0;
        next_cycle();
        even = 1'b1; deq_req = 1'b1;
        @(negedge clk);
        chk("fe_deq_ack", 32'(deq_ack), 1);
        next_cycle();
        even = 1'b0; deq_req = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("fe_req_cnt", 32'(count), 0);
        chk("fe_req_done", 32'(flush_done), 0);
        next_cycle();
        even = 1'b1; flush = 1'b0;
        @(negedge clk);
        chk("fe_done", 32'(flush_done), 1);
        chk("fe_done_oval", 32'(pq_ovalid), 0);
        next_cycle();
        even = 1'b1; req_valid = 4'h1;
        @(negedge clk);
        chk("fe_after_done", 32'(flush_done), 0);
        chk("fe_after_rdy", 32'(req_rdy), 32'h1);
        next_cycle();

        // reset mid-run with occupancy 3 (ptr = 1, count = 1)
        even = 1'b0; req_valid = 4'hF;
        next_cycle();
        even = 1'b1;
        @(negedge clk);
        chk("rr_fill1_rdy", 32'(req_rdy), 32'h2);
        next_cycle();
        even = 1'b0;
        next_cycle();
        even = 1'b1;
        @(negedge clk);
        chk("rr_fill2_rdy", 32'(req_rdy), 32'h4);
        next_cycle();
        even = 1'b1; deq_req = 1'b1;
        @(negedge clk);
        chk("rr_pre_cnt", 32'(count), 3);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outs("rst1");
        next_cycle();
        rst = 1'b1; deq_req = 1'b0; even = 1'b1; req_valid = 4'hF;
        @(negedge clk);
        chk("rr_first_rdy", 32'(req_rdy), 32'h1);
        chk("rr_first_idata", 32'(pq_idata), 32'h010);
        next_cycle();

        // reset mid-drain: no flush_done afterwards
        even = 1'b0; req_valid = '0; flush = 1'b1;
        next_cycle();
        flush = 1'b0; even = 1'b0;
        @(negedge clk);
        chk("rd_in_drain_cnt", 32'(count), 1);
        chk("rd_in_drain_done", 32'(flush_done), 0);
        rst = 1'b0;
        #1;
        chk("rd_rst_done", 32'(flush_done), 0);
        chk("rd_rst_cnt", 32'(count), 0);
        next_cycle();
        rst = 1'b1; even = 1'b0;
        @(negedge clk);
        chk("rd_after_done", 32'(flush_done), 0);
        next_cycle();
        @(negedge clk);
        chk("rd_after2_done", 32'(flush_done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
